dct_block_sched: RTL and testbench
==================================

# dct_block_sched

Block-level scheduler for the 8-point 1-D DCT engine `col_dct`. It accepts one 8×8 block of signed 8-bit samples, one row per beat, and feeds each row into the engine. It captures the eight 12-bit coefficient vectors into an internal transpose buffer, then streams the block out column-wise under downstream backpressure. It sits between the pixel-block reader and the quantiser in the preprocessing pipeline and owns the engine's valid and reset.

## Interface
- `TRANSPOSE`, default 1: 1 = output beat c carries coefficient c of rows 0..7; 0 = output beat r carries row r unchanged.
- `i_clk` in 1: single clock. All logic is rising-edge.
- `i_rst_n` in 1: synchronous, active-low reset. The engine's active-high reset is driven as `~i_rst_n`.
- `i_valid` in 1: input row valid.
- `o_ready` out 1: the scheduler accepts a row. A row transfers when `i_valid && o_ready`.
- `i_row` in 64: eight signed 8-bit samples; sample k = bits [8k+7:8k].
- `o_valid` out 1: output beat valid.
- `i_ready` in 1: downstream accepts. A beat transfers when `o_valid && i_ready`.
- `o_coef` out 96: eight signed 12-bit coefficients; element j = bits [12j+11:12j].
- `o_last` out 1: high on the 8th beat of a block.
- `o_busy` out 1: high in every state except IDLE.

## Operation
- **States:**
  - IDLE: `o_ready` = 1. The first row handshake moves to LOAD with row count 1.
  - LOAD: `o_ready` = 1 while row count < 8. The 8th row handshake moves to DRAIN.
  - DRAIN: `o_ready` = 0. Wait for outstanding engine results. When the 8th result is captured, move to OUT.
  - OUT: `o_ready` = 0, `o_valid` = 1. Beat count advances on each output handshake. The handshake on beat 7 returns to IDLE.
- **Engine feed:** engine `i_valid` = `i_valid && o_ready`; engine data = `i_row`, combinational. The engine has no stall input. The scheduler therefore never issues more than 8 rows per block, and the buffer is always free while rows are in flight.
- **Result capture:** each engine `o_valid` cycle writes the 8 outputs into buffer row = result count, in order `o_data0..o_data7`. The result count increments from 0 to 8.
- **Input gaps:** bubbles in `i_valid` during LOAD are legal. Results return in issue order with the same gaps.
- **Output mapping:**
  - `TRANSPOSE` = 1: `o_coef` element j = buf[j][beat].
  - `TRANSPOSE` = 0: element j = buf[beat][j].
- **Width:** no arithmetic in the scheduler. Coefficients pass bit-exact from the engine.
- **Counters:**
  - Row, result and beat counters are 4-bit.
  - Row count and result count clear on entering IDLE.
  - Beat count clears on entering OUT.
  - All counters saturate at their terminal state; there is no wrap.
- **Reset mid-operation:**
  - Returns to IDLE.
  - Clears all counters and the engine pipeline.
  - Discards the partial block.
  - Buffer contents are don't-care.
- **Back-to-back blocks:** a new block may begin in the cycle after the beat-7 handshake, because IDLE asserts `o_ready` immediately.

## Timing
- **Reset values:** `o_ready` = 1, `o_valid` = 0, `o_last` = 0, `o_busy` = 0, `o_coef` = 0.
- **Engine latency:** a row handshaking in cycle C has its result presented in cycle C+4 and captured at the end of C+4.
- **Block latency:** if row 7 handshakes in cycle C, `o_valid` first rises in cycle C+5.
  - Minimum block period with continuous input and `i_ready` = 1: 8 + 4 + 8 = 20 cycles.
- **Output stability:** `o_coef`, `o_last` and `o_valid` are registered or derived from registered state and buffer. They hold stable while `o_valid && !i_ready`.
- **No bypass:** `o_ready` never depends combinationally on `i_ready`.

## Structure
- **Package `dct_pkg`:**
  - `DCT_N` = 8, `DCT_IN_W` = 8, `DCT_OUT_W` = 12, `DCT_LAT` = 4.
  - State enum {IDLE, LOAD, DRAIN, OUT}.
  - Packed row and coefficient-vector typedefs.
- **Sub-module `dct_tbuf`:**
  - 8×8×12-bit register array.
  - Row-write port: write enable, row index, 96-bit vector.
  - Read port: index plus `TRANSPOSE` select returning a 96-bit vector.
- **Top level:** FSM, counters and the `col_dct` instance.

## Test plan
- **Constant block:** all samples = 10, `i_ready` held 1.
  - Required: 8 beats. Beat 0 is all elements = 80 and beats 1–7 are all zeros.
  - `o_last` on beat 7 only; first `o_valid` 5 cycles after the row-7 handshake.
- **Zero block with `TRANSPOSE` = 0:** 8 beats of 0. `o_busy` falls the cycle after the beat-7 handshake.
- **Input bubbles:** rows issued with `i_valid` alternating 1/0, constant 10.
  - Required: same output as the constant-block test.
  - `o_ready` drops exactly after the 8th row handshake.
- **Backpressure:** `i_ready` toggling every 3 cycles during OUT.
  - Required: `o_coef` holds across stalls and there are exactly 8 handshakes.
  - `o_ready` stays 0 until the last handshake, then is 1 the next cycle.
- **Reset mid-block:** `i_rst_n` = 0 for one cycle after 5 rows are accepted.
  - Required: all outputs return to reset values and no `o_valid` appears from the stale rows.
  - A following full constant-10 block produces the correct output.
- **Back-to-back:** two blocks, (all 10) then (all −10), fed continuously with `i_ready` = 1.
  - Required: second block beat 0 is all −80.
  - Block 2's row 0 is accepted in the cycle after block 1's beat-7 handshake.

Source files
------------

// File: rtl/dct_pkg.sv
// Shared widths, state encoding and row/coefficient vector types for the DCT block scheduler.
package dct_pkg;

    localparam int unsigned DCT_N     = 8;
    localparam int unsigned DCT_IN_W  = 8;
    localparam int unsigned DCT_OUT_W = 12;
    localparam int unsigned DCT_LAT   = 4;
    localparam int unsigned CNT_W     = 4;
    localparam int unsigned IDX_W     = 3;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DRAIN,
        OUT
    } state_e;

    typedef logic signed [DCT_IN_W-1:0]  sample_t;
    typedef sample_t     [DCT_N-1:0]     row_t;
    typedef logic signed [DCT_OUT_W-1:0] coef_t;
    typedef coef_t       [DCT_N-1:0]     coef_vec_t;
    typedef logic        [CNT_W-1:0]     cnt_t;

endpackage

// File: rtl/dct_block_sched_if.sv
// Row-in / coefficient-out handshake bundle of the DCT block scheduler.
interface dct_block_sched_if;
    import dct_pkg::*;

    logic      i_valid;
    logic      o_ready;
    row_t      i_row;
    logic      o_valid;
    logic      i_ready;
    coef_vec_t o_coef;
    logic      o_last;
    logic      o_busy;

    modport slave (
        input  i_valid, i_row, i_ready,
        output o_ready, o_valid, o_coef, o_last, o_busy
    );

    modport master (
        output i_valid, i_row, i_ready,
        input  o_ready, o_valid, o_coef, o_last, o_busy
    );

endinterface

// File: rtl/col_dct.sv
// 8-point 1-D DCT engine: integer cosine table scaled by 64, result floored by 64, fixed 4-cycle latency.
module col_dct
    import dct_pkg::*;
(
    input  logic  i_clk,
    input  logic  i_rst,
    input  logic  i_valid,
    input  row_t  i_data,
    output logic  o_valid,
    output coef_t o_data0,
    output coef_t o_data1,
    output coef_t o_data2,
    output coef_t o_data3,
    output coef_t o_data4,
    output coef_t o_data5,
    output coef_t o_data6,
    output coef_t o_data7
);

    localparam int unsigned ACC_W = 20;
    localparam int unsigned SHIFT = 6;

    typedef logic signed [ACC_W-1:0] acc_t;

    // 64*cos(m*pi/16), folded into the first quadrant
    function automatic acc_t cos64(input int m);
        int a;
        int v;
        bit neg;
        a = m % 32;
        if (a > 16) a = 32 - a;
        neg = 1'b0;
        if (a > 8) begin
            a   = 16 - a;
            neg = 1'b1;
        end
        case (a)
            0:       v = 64;
            1:       v = 63;
            2:       v = 59;
            3:       v = 53;
            4:       v = 45;
            5:       v = 36;
            6:       v = 24;
            7:       v = 12;
            default: v = 0;
        endcase
        return neg ? -ACC_W'(v) : ACC_W'(v);
    endfunction

    logic [DCT_LAT-1:0] v_q;
    row_t               x_q;
    acc_t               acc_d [DCT_N];
    acc_t               acc_q [DCT_N];
    coef_vec_t          y_q;
    coef_vec_t          z_q;

    // Valid pipeline, flushed by reset
    always_ff @(posedge i_clk) begin
        if (i_rst) v_q <= '0;
        else       v_q <= {v_q[DCT_LAT-2:0], i_valid};
    end

    // Dot products of the registered row against each cosine basis row
    always_comb begin
        for (int k = 0; k < int'(DCT_N); k++) begin
            acc_d[k] = '0;
            for (int n = 0; n < int'(DCT_N); n++) begin
                acc_d[k] = acc_d[k] + ACC_W'($signed(x_q[n])) * cos64((2 * n + 1) * k);
            end
        end
    end

    // Data pipeline: capture, multiply-accumulate, scale, present
    always_ff @(posedge i_clk) begin
        x_q   <= i_data;
        acc_q <= acc_d;
        for (int j = 0; j < int'(DCT_N); j++) begin
            y_q[j] <= DCT_OUT_W'(acc_q[j] >>> SHIFT);
        end
        z_q <= y_q;
    end

    assign o_valid = v_q[DCT_LAT-1];
    assign o_data0 = z_q[0];
    assign o_data1 = z_q[1];
    assign o_data2 = z_q[2];
    assign o_data3 = z_q[3];
    assign o_data4 = z_q[4];
    assign o_data5 = z_q[5];
    assign o_data6 = z_q[6];
    assign o_data7 = z_q[7];

endmodule

// File: rtl/dct_tbuf.sv
// 8x8 coefficient buffer: written one result row at a time, read as a row or as a column.
module dct_tbuf
    import dct_pkg::*;
#(
    parameter bit TRANSPOSE = 1'b1
) (
    input  logic             i_clk,
    input  logic             i_we,
    input  logic [IDX_W-1:0] i_widx,
    input  coef_vec_t        i_wdata,
    input  logic [IDX_W-1:0] i_ridx,
    output coef_vec_t        o_rdata
);

    coef_vec_t mem [DCT_N];

    // Row write
    always_ff @(posedge i_clk) begin
        if (i_we) mem[i_widx] <= i_wdata;
    end

    // Column read when transposing, plain row read otherwise
    always_comb begin
        o_rdata = '0;
        for (int j = 0; j < int'(DCT_N); j++) begin
            if (TRANSPOSE) o_rdata[j] = mem[IDX_W'(j)][i_ridx];
            else           o_rdata[j] = mem[i_ridx][j];
        end
    end

endmodule

// File: rtl/dct_block_sched.sv
// Block scheduler: feeds 8 rows into col_dct, buffers the 8 results, streams them out under backpressure.
module dct_block_sched
    import dct_pkg::*;
#(
    parameter bit TRANSPOSE = 1'b1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    dct_block_sched_if.slave bus
);

    localparam cnt_t CNT_LAST = CNT_W'(DCT_N - 1);
    localparam cnt_t CNT_FULL = CNT_W'(DCT_N);
    localparam cnt_t CNT_ONE  = CNT_W'(1);

    state_e    state_q, state_d;
    cnt_t      row_q, row_d;
    cnt_t      res_q, res_d;
    cnt_t      beat_q, beat_d;
    logic      ready_c, valid_c;
    logic      in_hs, out_hs, cap;
    logic      eng_rst, eng_valid;
    coef_vec_t eng_vec;
    coef_vec_t rd_vec;

    assign eng_rst = ~i_rst_n;

    // State and counter registers
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            row_q   <= '0;
            res_q   <= '0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            res_q   <= res_d;
            beat_q  <= beat_d;
        end
    end

    // Next state, saturating counters and handshake qualifiers
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        res_d   = res_q;
        beat_d  = beat_q;
        ready_c = 1'b0;
        valid_c = 1'b0;

        case (state_q)
            IDLE:    ready_c = 1'b1;
            LOAD:    ready_c = (row_q < CNT_FULL);
            DRAIN:   ready_c = 1'b0;
            OUT:     valid_c = 1'b1;
            default: ready_c = 1'b0;
        endcase

        in_hs  = bus.i_valid && ready_c;
        out_hs = valid_c && bus.i_ready;
        cap    = eng_valid && (res_q < CNT_FULL);

        if (in_hs && (row_q < CNT_FULL))  row_d  = row_q + CNT_ONE;
        if (cap)                          res_d  = res_q + CNT_ONE;
        if (out_hs && (beat_q < CNT_FULL)) beat_d = beat_q + CNT_ONE;

        case (state_q)
            IDLE: if (in_hs) state_d = LOAD;
            LOAD: if (in_hs && (row_q == CNT_LAST)) state_d = DRAIN;
            DRAIN: begin
                if (cap && (res_q == CNT_LAST)) begin
                    state_d = OUT;
                    beat_d  = '0;
                end
            end
            OUT: begin
                if (out_hs && (beat_q == CNT_LAST)) begin
                    state_d = IDLE;
                    row_d   = '0;
                    res_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Engine fed straight from the accepted row
    col_dct u_eng (
        .i_clk   (i_clk),
        .i_rst   (eng_rst),
        .i_valid (in_hs),
        .i_data  (bus.i_row),
        .o_valid (eng_valid),
        .o_data0 (eng_vec[0]),
        .o_data1 (eng_vec[1]),
        .o_data2 (eng_vec[2]),
        .o_data3 (eng_vec[3]),
        .o_data4 (eng_vec[4]),
        .o_data5 (eng_vec[5]),
        .o_data6 (eng_vec[6]),
        .o_data7 (eng_vec[7])
    );

    // Result rows land in buffer row = result count
    dct_tbuf #(.TRANSPOSE(TRANSPOSE)) u_tbuf (
        .i_clk   (i_clk),
        .i_we    (cap),
        .i_widx  (res_q[IDX_W-1:0]),
        .i_wdata (eng_vec),
        .i_ridx  (beat_q[IDX_W-1:0]),
        .o_rdata (rd_vec)
    );

    assign bus.o_ready = ready_c;
    assign bus.o_valid = valid_c;
    assign bus.o_coef  = valid_c ? rd_vec : '0;
    assign bus.o_last  = valid_c && (beat_q == CNT_LAST);
    assign bus.o_busy  = (state_q != IDLE);

endmodule

// File: tb/tb_dct_block_sched.sv
// Bench for dct_block_sched: both TRANSPOSE settings driven in lockstep and checked against a cosine reference.
module tb_dct_block_sched;
    import dct_pkg::*;

    typedef row_t blk_t [DCT_N];
    typedef struct {
        int fill;
        bit bubbles;
        int bp;
        int exp_dc;
    } vec_t;

    localparam real PI = 3.14159265358979;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   bp_mode = 0;
    bit   mon_en = 1'b0;

    int        rows_acc = 0;
    int        beats_done = 0;
    int        row7_cyc = 0;
    int        row0_cyc = 0;
    int        b7_cyc = 0;
    bit        prev_stall = 1'b0;
    coef_vec_t prev_t, prev_r;
    coef_vec_t exp_t_q [$];
    coef_vec_t exp_r_q [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dct_block_sched_if bus_t ();
    dct_block_sched_if bus_r ();

    dct_block_sched #(.TRANSPOSE(1'b1)) dut_t (.i_clk(clk), .i_rst_n(rst_n), .bus(bus_t.slave));
    dct_block_sched #(.TRANSPOSE(1'b0)) dut_r (.i_clk(clk), .i_rst_n(rst_n), .bus(bus_r.slave));

    assign bus_r.i_valid = bus_t.i_valid;
    assign bus_r.i_row   = bus_t.i_row;
    assign bus_r.i_ready = bus_t.i_ready;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic check_vec(input string name, input logic [95:0] act, input logic [95:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Rounded 64*cos((2n+1)k*pi/16)
    function automatic int cmul(input int k, input int n);
        return int'(64.0 * $cos(real'((2 * n + 1) * k) * PI / 16.0));
    endfunction

    // Queue the expected beats of a block for both read orders
    task automatic push_expected(input blk_t b);
        int m [DCT_N][DCT_N];
        coef_vec_t vt, vr;
        for (int r = 0; r < 8; r++)
            for (int k = 0; k < 8; k++) begin
                int s = 0;
                for (int n = 0; n < 8; n++) s += int'($signed(b[r][n])) * cmul(k, n);
                m[r][k] = s >>> 6;
            end
        for (int c = 0; c < 8; c++) begin
            for (int j = 0; j < 8; j++) begin
                vt[j] = coef_t'(m[j][c]);
                vr[j] = coef_t'(m[c][j]);
            end
            exp_t_q.push_back(vt);
            exp_r_q.push_back(vr);
        end
    endtask

    // Constant-input block: only the DC term of every row is nonzero
    task automatic push_const(input int dc);
        coef_vec_t vt, vr;
        for (int c = 0; c < 8; c++) begin
            for (int j = 0; j < 8; j++) begin
                vt[j] = (c == 0) ? coef_t'(dc) : '0;
                vr[j] = (j == 0) ? coef_t'(dc) : '0;
            end
            exp_t_q.push_back(vt);
            exp_r_q.push_back(vr);
        end
    endtask

    // Cycle monitor: protocol model plus scoreboard
    always @(negedge clk) begin
        if (mon_en) begin
            bit ev;
            ev = (rows_acc == 8) && (cyc >= row7_cyc + 5);
            check("t_ready", bus_t.o_ready, rows_acc < 8);
            check("r_ready", bus_r.o_ready, rows_acc < 8);
            check("t_busy", bus_t.o_busy, rows_acc > 0);
            check("r_busy", bus_r.o_busy, rows_acc > 0);
            check("t_valid", bus_t.o_valid, ev);
            check("r_valid", bus_r.o_valid, ev);
            check("t_last", bus_t.o_last, ev && (beats_done == 7));
            check("r_last", bus_r.o_last, ev && (beats_done == 7));
            if (prev_stall) begin
                check_vec("t_hold", bus_t.o_coef, prev_t);
                check_vec("r_hold", bus_r.o_coef, prev_r);
            end
            if (!rst_n) begin
                rows_acc   = 0;
                beats_done = 0;
                prev_stall = 1'b0;
            end else begin
                if (bus_t.i_valid && bus_t.o_ready) begin
                    if (rows_acc == 0) row0_cyc = cyc;
                    rows_acc++;
                    if (rows_acc == 8) row7_cyc = cyc;
                end
                if (bus_t.o_valid && bus_t.i_ready) begin
                    if (exp_t_q.size() == 0) begin
                        check("unexpected_beat", 1, 0);
                    end else begin
                        check_vec("t_coef", bus_t.o_coef, exp_t_q.pop_front());
                        check_vec("r_coef", bus_r.o_coef, exp_r_q.pop_front());
                    end
                    beats_done++;
                    if (beats_done == 8) begin
                        b7_cyc     = cyc;
                        rows_acc   = 0;
                        beats_done = 0;
                    end
                end
                prev_stall = bus_t.o_valid && !bus_t.i_ready;
                prev_t     = bus_t.o_coef;
                prev_r     = bus_r.o_coef;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_rows(input blk_t b, input int n, input bit bubbles);
        for (int k = 0; k < n; k++) begin
            int w = 0;
            if (bubbles && k > 0) begin
                bus_t.i_valid = 1'b0;
                bus_t.i_row   = row_t'({$urandom, $urandom});
                step();
            end
            bus_t.i_valid = 1'b1;
            bus_t.i_row   = b[k];
            while (!bus_t.o_ready && w < 100) begin
                step();
                w++;
            end
            if (w >= 100) check("row_accept_timeout", 1, 0);
            step();
        end
        bus_t.i_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int w = 0;
        while ((rows_acc != 0 || exp_t_q.size() != 0) && w < 400) begin
            step();
            w++;
        end
        if (w >= 400) check("drain_timeout", 1, 0);
        step();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_t_ready"}, bus_t.o_ready, 1);
        check({tag, "_t_valid"}, bus_t.o_valid, 0);
        check({tag, "_t_last"}, bus_t.o_last, 0);
        check({tag, "_t_busy"}, bus_t.o_busy, 0);
        check_vec({tag, "_t_coef"}, bus_t.o_coef, '0);
        check({tag, "_r_ready"}, bus_r.o_ready, 1);
        check({tag, "_r_valid"}, bus_r.o_valid, 0);
        check({tag, "_r_busy"}, bus_r.o_busy, 0);
        check_vec({tag, "_r_coef"}, bus_r.o_coef, '0);
    endtask

    function automatic blk_t const_blk(input int fill);
        blk_t b;
        for (int k = 0; k < 8; k++) b[k] = {8{sample_t'(fill)}};
        return b;
    endfunction

    // Downstream ready: held, toggled every 3 cycles, or random
    initial begin
        bus_t.i_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (bp_mode)
                0:       bus_t.i_ready = 1'b1;
                1:       bus_t.i_ready = ((cyc / 3) % 2) == 0;
                default: bus_t.i_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [7];
        blk_t b;

        tbl[0] = '{10,   1'b0, 0, 80};
        tbl[1] = '{0,    1'b0, 0, 0};
        tbl[2] = '{10,   1'b1, 0, 80};
        tbl[3] = '{10,   1'b0, 1, 80};
        tbl[4] = '{127,  1'b0, 2, 1016};
        tbl[5] = '{-128, 1'b1, 2, -1024};
        tbl[6] = '{-10,  1'b0, 1, -80};

        rst_n         = 1'b0;
        bus_t.i_valid = 1'b0;
        bus_t.i_row   = '0;
        step();
        step();
        check_reset_outputs("reset");
        rst_n  = 1'b1;
        mon_en = 1'b1;
        step();

        foreach (tbl[i]) begin
            bp_mode = tbl[i].bp;
            send_rows(const_blk(tbl[i].fill), 8, tbl[i].bubbles);
            push_const(tbl[i].exp_dc);
            wait_idle();
        end

        // Abort a block after five rows
        bp_mode = 0;
        send_rows(const_blk(10), 5, 1'b0);
        rst_n = 1'b0;
        step();
        check_reset_outputs("midreset");
        rst_n = 1'b1;
        repeat (12) step();
        send_rows(const_blk(10), 8, 1'b0);
        push_const(80);
        wait_idle();

        // Back-to-back blocks
        send_rows(const_blk(10), 8, 1'b0);
        push_const(80);
        send_rows(const_blk(-10), 8, 1'b0);
        check("b2b_row0_cycle", row0_cyc, b7_cyc + 1);
        push_const(-80);
        wait_idle();

        // Random blocks, random gaps and backpressure
        bp_mode = 2;
        for (int t = 0; t < 6; t++) begin
            for (int k = 0; k < 8; k++) b[k] = row_t'({$urandom, $urandom});
            send_rows(b, 8, 1'($urandom_range(0, 1)));
            push_expected(b);
        end
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
